sram_controller: RTL and testbench

//  Memory-side responder for MEM-stage load/store requests. Splits each 32-bit

---
 rtl/sram_controller.sv | 121 ++++++++++++
 tb/tb_sram_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
`default_nettype none
// ==========================================================================
// sram_controller : 32-bit load/store to 16-bit async SRAM, two half-word phases
// Rev 1.0
// ==========================================================================
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int c_CNT_W = (WAIT_CYCLES > 4) ? $clog2(WAIT_CYCLES - 2) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((WAIT_CYCLES > 3) ? (WAIT_CYCLES - 4) : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]        r_read_data;
    logic [16:0]        w_word;
    logic               w_drive;
    logic [15:0]        w_dq_out;
    logic               w_is_rd;

    assign w_word  = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign w_is_rd = rd_en & ~wr_en;

    // The bus is released whenever the SRAM output buffers may be active.
    assign sram_dq   = w_drive ? w_dq_out : 16'hzzzz;
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign read_data = r_read_data;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ready       = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b0;
        sram_addr   = 18'd0;
        w_drive     = 1'b0;
        w_dq_out    = 16'd0;
        case (r_state)
            S_IDLE: begin
                ready = ~(wr_en | rd_en);
                if (wr_en | rd_en) w_state_nxt = S_LO;
            end
            S_LO: begin
                sram_addr = {w_word, 1'b0};
                if (wr_en) begin
                    sram_we_n = 1'b0;
                    sram_oe_n = 1'b1;
                    w_drive   = 1'b1;
                    w_dq_out  = write_data[15:0];
                end
                w_state_nxt = S_HI;
            end
            S_HI: begin
                sram_addr = {w_word, 1'b1};
                if (wr_en) begin
                    sram_we_n = 1'b0;
                    sram_oe_n = 1'b1;
                    w_drive   = 1'b1;
                    w_dq_out  = write_data[31:16];
                end
                w_state_nxt = (WAIT_CYCLES == 3) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                ready       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_read_data <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_LO && w_is_rd) r_read_data[15:0]  <= sram_dq;
            if (r_state == S_HI && w_is_rd) r_read_data[31:16] <= sram_dq;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ==========================================================================
// tb_sram_controller : random load/store traffic on WAIT_CYCLES=6 and =3 DUTs
// Rev 1.0
// ==========================================================================
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en   [2];
    logic        rd_en   [2];
    logic [31:0] address [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic [17:0] saddr   [2];
    logic        we_n    [2];
    logic        oe_n    [2];
    logic        ce_n    [2];
    logic        ub_n    [2];
    logic        lb_n    [2];
    wire  [15:0] dq0, dq1;

    logic [15:0] mem     [2][64];
    logic [15:0] ref_mem [2][32];
    bit          ref_ok  [2][16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          c_WAIT [2] = '{6, 3};

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(6)) u_dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
        .address(address[0]), .write_data(wdata[0]), .read_data(rdata[0]),
        .ready(ready[0]), .sram_dq(dq0), .sram_addr(saddr[0]),
        .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]), .sram_ce_n(ce_n[0]),
        .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
    );

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
        .address(address[1]), .write_data(wdata[1]), .read_data(rdata[1]),
        .ready(ready[1]), .sram_dq(dq1), .sram_addr(saddr[1]),
        .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]), .sram_ce_n(ce_n[1]),
        .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
    );

    // Asynchronous SRAM: drives the bus whenever output enable is low.
    assign dq0 = !oe_n[0] ? mem[0][saddr[0][5:0]] : 16'hzzzz;
    assign dq1 = !oe_n[1] ? mem[1][saddr[1][5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!we_n[0]) mem[0][saddr[0][5:0]] <= dq0;
        if (!we_n[1]) mem[1][saddr[1][5:0]] <= dq1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bus(input int s);
        return (s == 0) ? dq0 : dq1;
    endfunction

    // One word access, entered at a negedge; b2b means the current cycle is DONE.
    task automatic access(input int s, input bit wr, input int idx,
                          input logic [31:0] data, input bit b2b);
        int n  = 0;
        int nw = 0;
        bit bus_ok = 1'b1;
        wr_en[s]   = wr;
        rd_en[s]   = !wr;
        address[s] = 32'(1024 + idx * 4);
        wdata[s]   = data;
        if (!b2b) begin
            #1 chk("req_ready_low", 32'(ready[s]), 32'd0);
        end
        do begin
            @(negedge clk);
            n++;
            if (b2b && n == 1) chk("b2b_idle_ready", 32'(ready[s]), 32'd0);
            if (!oe_n[s] && !we_n[s]) bus_ok = 1'b0;
            if (!wr && !we_n[s]) bus_ok = 1'b0;
            if (!we_n[s]) begin
                if (nw == 0) begin
                    chk("lo_addr", 32'(saddr[s]), 32'(idx * 2));
                    chk("lo_dq", 32'(bus(s)), 32'(data[15:0]));
                end else if (nw == 1) begin
                    chk("hi_addr", 32'(saddr[s]), 32'(idx * 2 + 1));
                    chk("hi_dq", 32'(bus(s)), 32'(data[31:16]));
                end
                nw++;
            end
        end while (!ready[s] && n < 40);
        chk("latency", 32'(n), 32'(c_WAIT[s] + (b2b ? 1 : 0)));
        chk("bus_ok", 32'(bus_ok), 32'd1);
        if (wr) begin
            chk("write_phases", 32'(nw), 32'd2);
            ref_mem[s][idx*2]   = data[15:0];
            ref_mem[s][idx*2+1] = data[31:16];
            ref_ok[s][idx]      = 1'b1;
        end else begin
            chk("read_data", rdata[s], {ref_mem[s][idx*2+1], ref_mem[s][idx*2]});
        end
    endtask

    task automatic drop(input int s);
        wr_en[s] = 1'b0;
        rd_en[s] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            wr_en[s] = 1'b0; rd_en[s] = 1'b0; address[s] = 32'd0; wdata[s] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", 32'(ready[s]), 32'd1);
            chk("rst_we_n", 32'(we_n[s]), 32'd1);
            chk("rst_oe_n", 32'(oe_n[s]), 32'd0);
            chk("rst_addr", 32'(saddr[s]), 32'd0);
            chk("rst_rdata", rdata[s], 32'd0);
            chk("tied_ctl", {29'd0, ce_n[s], ub_n[s], lb_n[s]}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready[0]), 32'd1);
            chk("idle_we_n", 32'(we_n[0]), 32'd1);
        end

        // Directed: store/load at 1024, then store @1032 with back-to-back load.
        for (int s = 0; s < 2; s++) begin
            access(s, 1'b1, 0, 32'hDEADBEEF, 1'b0);
            drop(s); @(negedge clk);
            access(s, 1'b0, 0, 32'd0, 1'b0);
            drop(s); @(negedge clk);
            access(s, 1'b1, 2, 32'h1234_5678, 1'b0);
            access(s, 1'b0, 2, 32'd0, 1'b1);
            drop(s); @(negedge clk);
        end

        for (int s = 0; s < 2; s++) begin
            bit b2b = 1'b0;
            for (int t = 0; t < 30; t++) begin
                int idx = int'($urandom_range(0, 15));
                bit wr  = ($urandom_range(0, 1) == 1) || !ref_ok[s][idx];
                access(s, wr, idx, $urandom, b2b);
                b2b = ($urandom_range(0, 2) != 0);
                if (!b2b) begin
                    drop(s);
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
            drop(s);
            @(negedge clk);
        end

        // Reset during the HI phase of a store aborts at once.
        wr_en[0] = 1'b1; rd_en[0] = 1'b0;
        address[0] = 32'(1024 + 5 * 4); wdata[0] = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_hi_addr", 32'(saddr[0]), 32'd11);
        rst = 1'b1;
        #1;
        chk("abort_we_n", 32'(we_n[0]), 32'd1);
        chk("abort_oe_n", 32'(oe_n[0]), 32'd0);
        chk("abort_rdata", rdata[0], 32'd0);
        chk("abort_ready_req", 32'(ready[0]), 32'd0);
        ref_mem[0][10] = 16'hF00D;
        drop(0);
        #1 chk("abort_ready_idle", 32'(ready[0]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (ref_ok[0][5]) begin
            access(0, 1'b0, 5, 32'd0, 1'b0);
            drop(0);
        end
        access(0, 1'b1, 5, 32'h0BAD_F00D, 1'b0);
        drop(0); @(negedge clk);
        access(0, 1'b0, 5, 32'd0, 1'b0);
        drop(0); @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
